// File: rtl/spi_xfer_ctrl_if.sv
// Command/response channel bundle for spi_xfer_ctrl.
// master = command issuer / response consumer, slave = the sequencer.
interface spi_xfer_ctrl_if #(
    parameter int CHAR_LEN_BITS = 7,
    parameter int DIV_WIDTH     = 16,
    parameter int SS_NB         = 8
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [31:0]              cmd_data;
    logic [CHAR_LEN_BITS-1:0] cmd_len;
    logic [2:0]               cmd_mode;
    logic [SS_NB-1:0]         cmd_ss;
    logic                     cmd_last;
    logic [DIV_WIDTH-1:0]     cmd_div;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_data;

    modport master (
        output cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_ss, cmd_last, cmd_div, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_ss, cmd_last, cmd_div, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer sequencer: command accept, shift-register load/go, sclk and edge
// strobes, slave selects, response channel. SPI_XFER_CTRL_IRQ_EN adds irq/irq_clr.
module spi_xfer_ctrl #(
    parameter int CHAR_LEN_BITS = 7,
    parameter int DIV_WIDTH     = 16,
    parameter int SS_NB         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    spi_xfer_ctrl_if.slave           bus,
    output logic [3:0]               sh_latch,
    output logic [3:0]               sh_byte_sel,
    output logic [31:0]              sh_p_in,
    output logic [CHAR_LEN_BITS-1:0] sh_len,
    output logic [2:0]               sh_mode,
    output logic                     sh_go,
    output logic                     sh_pos_edge,
    output logic                     sh_neg_edge,
    output logic                     sh_s_clk,
    input  logic                     sh_tip,
    input  logic                     sh_last,
    input  logic [31:0]              sh_p_out,
    output logic [SS_NB-1:0]         ss_pad_o,
`ifdef SPI_XFER_CTRL_IRQ_EN
    output logic                     irq,
    input  logic                     irq_clr,
`endif
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [31:0]              data_q;
    logic [CHAR_LEN_BITS-1:0] len_q;
    logic [2:0]               mode_q;
    logic                     last_q;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [DIV_WIDTH-1:0]     cnt;
    logic                     s_clk;
    logic                     term;
    logic                     go_sent;
    logic [31:0]              rsp_data_q;
    logic [SS_NB-1:0]         ss_pad_q;

    logic accept, shift_run, xfer_end, rsp_take, edge_tick;

    assign accept    = bus.cmd_valid && (state == S_IDLE);
    assign shift_run = (state == S_SHIFT) && sh_tip;
    assign xfer_end  = (state == S_SHIFT) && !sh_tip;
    assign rsp_take  = (state == S_DONE) && bus.rsp_ready;
    // Once the terminating strobe is out, no further strobes until the shifter drops tip.
    assign edge_tick = (state == S_SHIFT) && (cnt == '0) && !term;

    assign sh_pos_edge  = edge_tick && !s_clk;
    assign sh_neg_edge  = edge_tick && s_clk;
    assign sh_s_clk     = s_clk;
    assign sh_len       = len_q;
    assign sh_mode      = mode_q;
    assign ss_pad_o     = ss_pad_q;
    assign bus.rsp_data = rsp_data_q;

    always_comb begin
        state_nxt     = state;
        sh_latch      = 4'b0000;
        sh_byte_sel   = 4'h0;
        sh_p_in       = '0;
        sh_go         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                bus.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (accept) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sh_latch    = 4'b0001;
                sh_byte_sel = 4'hF;
                sh_p_in     = data_q;
                state_nxt   = S_START;
            end
            S_START: begin
                sh_go = !go_sent;
                if (sh_tip) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (!sh_tip) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            data_q     <= '0;
            len_q      <= '0;
            mode_q     <= '0;
            last_q     <= 1'b0;
            div_q      <= '0;
            cnt        <= '0;
            s_clk      <= 1'b0;
            term       <= 1'b0;
            go_sent    <= 1'b0;
            rsp_data_q <= '0;
            ss_pad_q   <= '1;
        end else begin
            state   <= state_nxt;
            go_sent <= (state == S_START);

            if (accept) begin
                data_q   <= bus.cmd_data;
                len_q    <= bus.cmd_len;
                mode_q   <= bus.cmd_mode;
                last_q   <= bus.cmd_last;
                div_q    <= bus.cmd_div;
                ss_pad_q <= ~bus.cmd_ss;
            end else if (rsp_take && last_q) begin
                ss_pad_q <= '1;
            end

            if (xfer_end) rsp_data_q <= sh_p_out;

            // Each sclk phase spans div+1 clocks; a zero count with last set
            // yields one extra pos strobe that does not move sclk.
            if (shift_run) begin
                if (cnt == '0) begin
                    cnt <= div_q;
                    if (!term) begin
                        if (s_clk)        s_clk <= 1'b0;
                        else if (sh_last) term  <= 1'b1;
                        else              s_clk <= 1'b1;
                    end
                end else begin
                    cnt <= cnt - DIV_WIDTH'(1);
                end
            end else begin
                cnt   <= (state == S_START) ? div_q : '0;
                s_clk <= 1'b0;
                term  <= 1'b0;
            end
        end
    end

`ifdef SPI_XFER_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 irq <= 1'b0;
        else if (xfer_end)          irq <= 1'b1;
        else if (irq_clr || accept) irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: behavioural shift-register responder plus directed and
// randomized transfers checked against expected edge counts, timing and RX words.
module tb_spi_xfer_ctrl;
    localparam int CLB = 7;
    localparam int DW  = 16;
    localparam int SSN = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sh_latch, sh_byte_sel;
    logic [31:0] sh_p_in, sh_p_out;
    logic [6:0]  sh_len;
    logic [2:0]  sh_mode;
    logic        sh_go, sh_pos_edge, sh_neg_edge, sh_s_clk, sh_tip, sh_last;
    logic [7:0]  ss_pad_o;
    logic        busy;
`ifdef SPI_XFER_CTRL_IRQ_EN
    logic        irq, irq_clr;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rx_word;

    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.CHAR_LEN_BITS(CLB), .DIV_WIDTH(DW), .SS_NB(SSN)) bus ();

    spi_xfer_ctrl #(.CHAR_LEN_BITS(CLB), .DIV_WIDTH(DW), .SS_NB(SSN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sh_latch(sh_latch), .sh_byte_sel(sh_byte_sel), .sh_p_in(sh_p_in),
        .sh_len(sh_len), .sh_mode(sh_mode), .sh_go(sh_go),
        .sh_pos_edge(sh_pos_edge), .sh_neg_edge(sh_neg_edge), .sh_s_clk(sh_s_clk),
        .sh_tip(sh_tip), .sh_last(sh_last), .sh_p_out(sh_p_out),
        .ss_pad_o(ss_pad_o),
`ifdef SPI_XFER_CTRL_IRQ_EN
        .irq(irq), .irq_clr(irq_clr),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift-register stand-in: counts bits down on falling strobes, raises last at
    // zero, drops tip on the following rising strobe, shifts rx_word in MSB-first.
    initial begin
        int  sr_n, sr_cnt, sr_step;
        bit  g, pe, ne;
        logic [6:0] ln;
        sh_tip = 1'b0; sh_last = 1'b1; sh_p_out = '0;
        sr_n = 1; sr_cnt = 0; sr_step = 0;
        forever begin
            @(negedge clk);
            g = sh_go; pe = sh_pos_edge; ne = sh_neg_edge; ln = sh_len;
            @(posedge clk); #1;
            if (!rst_n) begin
                sh_tip = 1'b0; sr_cnt = 0;
            end else if (g) begin
                sh_tip = 1'b1; sr_n = (ln == 0) ? 128 : int'(ln);
                sr_cnt = sr_n; sr_step = 0; sh_p_out = '0;
            end else if (sh_tip) begin
                if (ne && sr_cnt != 0) begin
                    sh_p_out = {sh_p_out[30:0], rx_word[(sr_n - 1 - sr_step) % 32]};
                    sr_step++; sr_cnt--;
                end
                if (pe && sr_cnt == 0) sh_tip = 1'b0;
            end else begin
                sh_p_out = $urandom;
            end
            sh_last = (sr_cnt == 0);
        end
    end

    task automatic xfer(input logic [31:0] data, input logic [6:0] len, input logic [2:0] mode,
                        input logic [7:0] ss, input logic last, input logic [15:0] div,
                        input int hold, input bit early);
        int n_exp, cyc, go_at, go_cnt, rises, falls, phase, bad_phase, bad_ss, bad_cfg, bad_hold, both;
        logic       prev_clk;
        logic [31:0] exp_rx;
        logic [7:0] ss_act;
        n_exp   = (len == 0) ? 128 : int'(len);
        rx_word = $urandom;
        exp_rx  = (n_exp >= 32) ? rx_word : (rx_word & ((32'h1 << n_exp) - 32'h1));
        ss_act  = ~ss;
        @(negedge clk);
        bus.rsp_ready = early;
        cyc = 0;
        while (bus.cmd_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1; bus.cmd_data = data; bus.cmd_len = len; bus.cmd_mode = mode;
        bus.cmd_ss = ss; bus.cmd_last = last; bus.cmd_div = div;
        @(posedge clk); #1;
        // valid stays high with scrambled fields: must be ignored until IDLE
        bus.cmd_data = $urandom; bus.cmd_len = 7'($urandom); bus.cmd_mode = ~mode;
        bus.cmd_ss = 8'($urandom); bus.cmd_last = ~last; bus.cmd_div = 16'($urandom_range(0, 7));
        cyc = 0; go_at = -1; go_cnt = 0; rises = 0; falls = 0; phase = 0;
        bad_phase = 0; bad_ss = 0; bad_cfg = 0; both = 0; prev_clk = 1'b0;
        while (bus.rsp_valid !== 1'b1 && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (cyc == 1) begin
                chk("load_latch", sh_latch, 4'b0001);
                chk("load_byte_sel", sh_byte_sel, 4'hF);
                chk("load_p_in", sh_p_in, data);
            end
            if (sh_go === 1'b1) begin go_cnt++; if (go_at < 0) go_at = cyc; end
            if (sh_pos_edge === 1'b1 && sh_neg_edge === 1'b1) both++;
            if (sh_s_clk !== prev_clk) begin
                if (sh_s_clk) rises++; else falls++;
                if (!(sh_s_clk && rises == 1) && phase != int'(div) + 1) bad_phase++;
                phase = 1;
            end else begin
                phase++;
            end
            prev_clk = sh_s_clk;
            if (ss_pad_o !== ss_act) bad_ss++;
            if (sh_len !== len || sh_mode !== mode) bad_cfg++;
        end
        bus.cmd_valid = 1'b0;
        chk("rsp_valid_seen", bus.rsp_valid, 1);
        chk("go_cycle", go_at, 2);
        chk("go_pulses", go_cnt, 1);
        chk("sclk_rises", rises, n_exp);
        chk("sclk_falls", falls, n_exp);
        chk("sclk_phase_len", bad_phase, 0);
        chk("strobe_overlap", both, 0);
        chk("ss_during", bad_ss, 0);
        chk("cfg_held", bad_cfg, 0);
        chk("rsp_data", bus.rsp_data, exp_rx);
        chk("cmd_ready_done", bus.cmd_ready, 0);
        chk("sclk_idle_low", sh_s_clk, 0);
`ifdef SPI_XFER_CTRL_IRQ_EN
        chk("irq_set", irq, 1);
`endif
        bad_hold = 0;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_rx ||
                    bus.cmd_ready !== 1'b0 || ss_pad_o !== ss_act) bad_hold++;
            end
            bus.rsp_ready = 1'b1;
        end
        chk("rsp_hold_stable", bad_hold, 0);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_clear", bus.rsp_valid, 0);
        chk("cmd_ready_after", bus.cmd_ready, 1);
        chk("busy_after", busy, 0);
        chk("ss_after", ss_pad_o, last ? 8'hFF : ss_act);
`ifdef SPI_XFER_CTRL_IRQ_EN
        irq_clr = 1'b1;
        @(posedge clk); #1;
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 0);
`endif
    endtask

    initial begin
        int cyc;
        bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_len = '0; bus.cmd_mode = '0;
        bus.cmd_ss = '0; bus.cmd_last = 1'b0; bus.cmd_div = '0; bus.rsp_ready = 1'b0;
`ifdef SPI_XFER_CTRL_IRQ_EN
        irq_clr = 1'b0;
`endif
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_go", sh_go, 0);
        chk("rst_latch", sh_latch, 0);
        chk("rst_p_in", sh_p_in, 0);
        chk("rst_strobes", {sh_pos_edge, sh_neg_edge}, 0);
        chk("rst_sclk", sh_s_clk, 0);
        chk("rst_ss", ss_pad_o, 8'hFF);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        xfer(32'h0000_00A5, 7'd8, 3'd0, 8'h01, 1'b1, 16'd0, 0, 1'b0);
        xfer($urandom, 7'd8, 3'($urandom), 8'h02, 1'b1, 16'd3, 10, 1'b0);
        xfer($urandom, 7'd0, 3'($urandom), 8'h80, 1'b1, 16'd1, 2, 1'b0);
        xfer($urandom, 7'd12, 3'd5, 8'h04, 1'b0, 16'd1, 0, 1'b1);
        xfer($urandom, 7'd33, 3'd2, 8'h04, 1'b1, 16'd0, 0, 1'b1);

        for (int i = 0; i < 6; i++) begin
            xfer($urandom, (i == 3) ? 7'd0 : 7'($urandom_range(1, 40)), 3'($urandom),
                 8'($urandom_range(1, 255)), 1'($urandom), 16'($urandom_range(0, 3)),
                 $urandom_range(0, 4), 1'($urandom));
        end

        xfer($urandom, 7'd1, 3'd0, 8'h10, 1'b1, 16'd300, 1, 1'b0);

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_data = $urandom; bus.cmd_len = 7'd16; bus.cmd_mode = 3'd1;
        bus.cmd_ss = 8'h3C; bus.cmd_last = 1'b0; bus.cmd_div = 16'd2;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (sh_s_clk !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("abort_sclk_running", sh_s_clk, 1);
        chk("abort_ss_low", ss_pad_o, 8'hC3);
        rst_n = 1'b0;
        #1;
        chk("abort_sclk", sh_s_clk, 0);
        chk("abort_ss", ss_pad_o, 8'hFF);
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xfer($urandom, 7'd10, 3'd3, 8'h21, 1'b1, 16'd2, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
